pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture_pkg.sv | 38 +++
 rtl/wb_bus.sv | 15 +
 rtl/pwm_capture_sync.sv | 30 +++
 rtl/pwm_capture.sv | 142 ++++++++++++++
 tb/tb_pwm_capture.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: register map, bit positions,
// FSM states and small arithmetic helpers.
package pwm_capture_pkg;

  localparam logic [31:0] OFF_CONTROL  = 32'h00;
  localparam logic [31:0] OFF_STATUS   = 32'h04;
  localparam logic [31:0] OFF_PRESCALE = 32'h08;
  localparam logic [31:0] OFF_PERIOD   = 32'h0C;
  localparam logic [31:0] OFF_HIGH     = 32'h10;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_IRQEN    = 1;
  localparam int CTRL_POLARITY = 2;
  localparam int STAT_VALID    = 0;
  localparam int STAT_OVERRUN  = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } capture_state_e;

  // Measurement counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic inc);
    return (inc && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                              input logic [31:0] new_value,
                                              input logic [3:0]  sel);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[i*8 +: 8] = sel[i] ? new_value[i*8 +: 8] : old_value[i*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_bus.sv
// Minimal single-cycle Wishbone register bus.
interface wb_bus;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport slave  (input cyc, stb, we, adr, wdata, sel, output rdata, ack, err);
  modport master (output cyc, stb, we, adr, wdata, sel, input rdata, ack, err);
endinterface

// File: rtl/pwm_capture_sync.sv
// Two-flop synchronizer for the asynchronous PWM pin plus single-cycle
// rise/fall pulses against the previous synchronized sample.
module pwm_capture_sync (
  input  logic clk_in,
  input  logic reset_in,
  input  logic async_sig,
  output logic rise,
  output logic fall
);

  logic meta;
  logic stable;
  logic prev;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      meta   <= 1'b0;
      stable <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= async_sig;
      stable <= meta;
      prev   <= stable;
    end
  end

  assign rise = stable & ~prev;
  assign fall = ~stable & prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / active-level time capture with a Wishbone register interface.
// Results are in prescaled ticks; counters saturate rather than wrap.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h4040
) (
  input  logic  clk_in,
  input  logic  reset_in,
  input  logic  capture_in,
  output logic  capture_irq_out,
  wb_bus.slave  bus_slave
);

  logic           rise;
  logic           fall;
  logic [2:0]     ctrl;
  logic [1:0]     status;
  logic [31:0]    prescale;
  logic [31:0]    period;
  logic [31:0]    high_time;
  logic [31:0]    counter;
  logic [31:0]    prescaler;
  logic [31:0]    high_latch;
  capture_state_e state;

  logic [31:0] offset;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_pre;
  logic [1:0]  status_clr;
  logic        reconfig;
  logic        active_edge;
  logic        inactive_edge;
  logic        capture;
  logic        tick;
  logic [31:0] count_next;
  logic [31:0] read_data;

  pwm_capture_sync u_sync (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .async_sig (capture_in),
    .rise      (rise),
    .fall      (fall)
  );

  assign offset     = bus_slave.adr - BaseAddr;
  assign wr         = bus_slave.cyc & bus_slave.stb & bus_slave.we;
  assign wr_ctrl    = wr & (offset == OFF_CONTROL) & bus_slave.sel[0];
  assign wr_pre     = wr & (offset == OFF_PRESCALE);
  assign status_clr = (wr && (offset == OFF_STATUS) && bus_slave.sel[0]) ?
                      bus_slave.wdata[1:0] : 2'b00;

  // Changing the time base or the edge sense invalidates any measurement in flight.
  assign reconfig = ctrl[CTRL_ENABLE] &
                    (wr_pre | (wr_ctrl & (bus_slave.wdata[CTRL_POLARITY] != ctrl[CTRL_POLARITY])));

  assign active_edge   = ctrl[CTRL_POLARITY] ? fall : rise;
  assign inactive_edge = ctrl[CTRL_POLARITY] ? rise : fall;
  assign capture       = ctrl[CTRL_ENABLE] & ~reconfig & (state == ST_MEASURE) & active_edge;
  assign tick          = (prescaler == prescale);
  assign count_next    = sat_inc(counter, tick);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ctrl     <= 3'b000;
      prescale <= '0;
      status   <= 2'b00;
    end else begin
      if (wr_ctrl) ctrl <= bus_slave.wdata[2:0];
      if (wr_pre)  prescale <= merge_bytes(prescale, bus_slave.wdata, bus_slave.sel);
      // A capture in the same cycle as a clear leaves the bit set.
      status[STAT_VALID]   <= (status[STAT_VALID] & ~status_clr[STAT_VALID]) | capture;
      status[STAT_OVERRUN] <= (status[STAT_OVERRUN] & ~status_clr[STAT_OVERRUN]) |
                              (capture & status[STAT_VALID]);
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state      <= ST_IDLE;
      counter    <= '0;
      prescaler  <= '0;
      high_latch <= '0;
      period     <= '0;
      high_time  <= '0;
    end else if (!ctrl[CTRL_ENABLE]) begin
      state     <= ST_IDLE;
      counter   <= '0;
      prescaler <= '0;
    end else if (reconfig) begin
      state     <= ST_ARMED;
      counter   <= '0;
      prescaler <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_ARMED;
          counter   <= '0;
          prescaler <= '0;
        end
        ST_ARMED: begin
          counter   <= '0;
          prescaler <= '0;
          if (active_edge) state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (active_edge) begin
            period    <= count_next;
            high_time <= high_latch;
            counter   <= '0;
            prescaler <= '0;
          end else begin
            counter   <= count_next;
            prescaler <= tick ? '0 : prescaler + 32'd1;
            if (inactive_edge) high_latch <= count_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    read_data = '0;
    case (offset)
      OFF_CONTROL:  read_data = {29'd0, ctrl};
      OFF_STATUS:   read_data = {30'd0, status};
      OFF_PRESCALE: read_data = prescale;
      OFF_PERIOD:   read_data = period;
      OFF_HIGH:     read_data = high_time;
      default:      read_data = '0;
    endcase
  end

  assign bus_slave.rdata = read_data;
  assign bus_slave.ack   = bus_slave.cyc & bus_slave.stb;
  assign bus_slave.err   = 1'b0;
  assign capture_irq_out = status[STAT_VALID] & ctrl[CTRL_IRQEN];

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a timestamp-based model of the capture
// rules checked every cycle against the interrupt, plus directed register checks.
module tb_pwm_capture;

  localparam logic [31:0] BASE   = 32'h4040;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_PRE  = BASE + 32'h8;
  localparam logic [31:0] A_PER  = BASE + 32'hC;
  localparam logic [31:0] A_HIGH = BASE + 32'h10;
  localparam logic [31:0] A_NONE = BASE + 32'h14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pin   = 1'b0;
  logic irq;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rd_ack;
  logic rd_err;

  wb_bus bus ();

  pwm_capture #(.BaseAddr(BASE)) dut (
    .clk_in          (clk),
    .reset_in        (rst_n),
    .capture_in      (pin),
    .capture_irq_out (irq),
    .bus_slave       (bus)
  );

  always #5 clk = ~clk;

  // Model: pin samples delayed three clocks, edge timestamps, results as cycles/(PRESCALE+1).
  logic [2:0]  hist;
  logic [63:0] cyc_no;
  logic [63:0] t_act;
  logic        m_en, m_irqen, m_pol, m_armed, m_meas, m_valid, m_ovr;
  logic [31:0] m_pre, m_period, m_high, m_hl;

  function automatic logic [31:0] scaled(input logic [63:0] cycles, input logic [31:0] pre);
    logic [63:0] q;
    q = cycles / ({32'd0, pre} + 64'd1);
    return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 3'b000; cyc_no <= '0; t_act <= '0;
      m_en <= 0; m_irqen <= 0; m_pol <= 0; m_armed <= 0; m_meas <= 0;
      m_valid <= 0; m_ovr <= 0; m_pre <= '0; m_period <= '0; m_high <= '0; m_hl <= '0;
    end else begin : step
      logic        wr, act, inact, reconf, cap;
      logic [1:0]  clr;
      logic [63:0] len;
      wr     = bus.cyc && bus.stb && bus.we;
      act    = m_pol ? (hist[2] && !hist[1]) : (!hist[2] && hist[1]);
      inact  = m_pol ? (!hist[2] && hist[1]) : (hist[2] && !hist[1]);
      reconf = m_en && wr && ((bus.adr == A_PRE) ||
               ((bus.adr == A_CTRL) && bus.sel[0] && (bus.wdata[2] != m_pol)));
      cap    = m_en && !reconf && m_meas && act;
      len    = cyc_no - t_act;
      clr    = (wr && (bus.adr == A_STAT) && bus.sel[0]) ? bus.wdata[1:0] : 2'b00;
      m_valid <= (m_valid && !clr[0]) || cap;
      m_ovr   <= (m_ovr && !clr[1]) || (cap && m_valid);
      if (!m_en) begin
        m_armed <= 0; m_meas <= 0;
      end else if (reconf) begin
        m_armed <= 1; m_meas <= 0;
      end else if (!m_armed && !m_meas) begin
        m_armed <= 1;
      end else if (m_armed && act) begin
        m_armed <= 0; m_meas <= 1; t_act <= cyc_no;
      end else if (cap) begin
        m_period <= scaled(len, m_pre); m_high <= m_hl; t_act <= cyc_no;
      end else if (m_meas && inact) begin
        m_hl <= scaled(len, m_pre);
      end
      if (wr && (bus.adr == A_CTRL) && bus.sel[0]) {m_pol, m_irqen, m_en} <= bus.wdata[2:0];
      if (wr && (bus.adr == A_PRE)) begin
        for (int i = 0; i < 4; i++) if (bus.sel[i]) m_pre[i*8 +: 8] <= bus.wdata[i*8 +: 8];
      end
      hist   <= {hist[1:0], pin};
      cyc_no <= cyc_no + 64'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) checkOutput("irq_vs_model", {31'd0, irq}, {31'd0, m_valid & m_irqen});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = a; bus.wdata = d; bus.sel = s;
    tick(1);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = a;
    #2;
    d = bus.rdata; rd_ack = bus.ack; rd_err = bus.err;
    bus.cyc = 1'b0; bus.stb = 1'b0;
    tick(1);
  endtask

  // One bus read compared against both the model and a hand-computed literal.
  task automatic checkReg(input string name, input logic [31:0] a,
                          input logic [31:0] model_val, input logic [31:0] literal);
    logic [31:0] d;
    busRead(a, d);
    checkOutput({name, "_model"}, d, model_val);
    checkOutput({name, "_lit"}, d, literal);
  endtask

  task automatic applyStimulus(input int high_cycles, input int low_cycles, input int periods);
    for (int p = 0; p < periods; p++) begin
      pin = 1'b1; tick(high_cycles);
      pin = 1'b0; tick(low_cycles);
    end
  endtask

  initial begin
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = '0; bus.wdata = '0; bus.sel = '0;
    tick(3);
    checkOutput("irq_in_reset", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    $display("[TB] reset values");
    checkReg("rst_ctrl", A_CTRL, {29'd0, m_pol, m_irqen, m_en}, 32'd0);
    checkReg("rst_stat", A_STAT, {30'd0, m_ovr, m_valid}, 32'd0);
    checkReg("rst_pre", A_PRE, m_pre, 32'd0);
    checkReg("rst_period", A_PER, m_period, 32'd0);
    checkReg("rst_high", A_HIGH, m_high, 32'd0);

    $display("[TB] prescale 0, rising polarity");
    busWrite(A_CTRL, 32'h3);
    applyStimulus(10, 30, 2);
    checkReg("p0_period", A_PER, m_period, 32'd40);
    checkReg("p0_high", A_HIGH, m_high, 32'd10);
    checkReg("p0_stat", A_STAT, {30'd0, m_ovr, m_valid}, 32'h1);
    checkOutput("p0_irq", {31'd0, irq}, 32'd1);

    $display("[TB] prescale 3");
    busWrite(A_PRE, 32'd3);
    busWrite(A_STAT, 32'h3);
    applyStimulus(10, 30, 2);
    checkReg("p3_period", A_PER, m_period, 32'd10);
    checkReg("p3_high", A_HIGH, m_high, 32'd2);

    $display("[TB] falling polarity");
    busWrite(A_PRE, 32'd0);
    busWrite(A_CTRL, 32'h7);
    busWrite(A_STAT, 32'h3);
    applyStimulus(10, 30, 2);
    checkReg("pol_period", A_PER, m_period, 32'd40);
    checkReg("pol_high", A_HIGH, m_high, 32'd30);

    $display("[TB] overrun and clear");
    busWrite(A_CTRL, 32'h3);
    busWrite(A_STAT, 32'h3);
    applyStimulus(10, 30, 4);
    checkReg("ovr_stat", A_STAT, {30'd0, m_ovr, m_valid}, 32'h3);
    checkOutput("ovr_irq", {31'd0, irq}, 32'd1);
    busWrite(A_STAT, 32'h3);
    checkReg("clr_stat", A_STAT, {30'd0, m_ovr, m_valid}, 32'h0);
    checkOutput("clr_irq", {31'd0, irq}, 32'd0);

    $display("[TB] byte lanes and decode");
    busWrite(A_CTRL, 32'h0);
    busWrite(A_PRE, 32'hAABB_CCDD, 4'b0101);
    checkReg("sel_pre", A_PRE, m_pre, 32'h00BB_00DD);
    busWrite(A_PRE, 32'd0);
    busWrite(A_NONE, 32'hFFFF_FFFF);
    checkReg("none_read", A_NONE, 32'd0, 32'd0);
    busWrite(A_CTRL, 32'hFFFF_FFFB);
    checkReg("ctrl_mask", A_CTRL, {29'd0, m_pol, m_irqen, m_en}, 32'h3);
    checkOutput("ack", {31'd0, rd_ack}, 32'd1);
    checkOutput("err", {31'd0, rd_err}, 32'd0);

    $display("[TB] disable mid-period");
    applyStimulus(7, 13, 1);
    busWrite(A_CTRL, 32'h0);
    tick(5);
    checkReg("dis_stat", A_STAT, {30'd0, m_ovr, m_valid}, 32'h0);
    busWrite(A_CTRL, 32'h3);
    pin = 1'b1; tick(4);
    checkReg("dis_arm_only", A_STAT, {30'd0, m_ovr, m_valid}, 32'h0);
    tick(2);
    pin = 1'b0; tick(13);
    pin = 1'b1; tick(5);
    checkReg("dis_period", A_PER, m_period, 32'd20);
    checkReg("dis_high", A_HIGH, m_high, 32'd7);
    checkReg("dis_stat2", A_STAT, {30'd0, m_ovr, m_valid}, 32'h1);

    $display("[TB] reset mid-period");
    pin = 1'b0; tick(5);
    rst_n = 1'b0;
    tick(2);
    checkOutput("irq_mid_reset", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    checkReg("mr_stat", A_STAT, {30'd0, m_ovr, m_valid}, 32'h0);
    checkReg("mr_period", A_PER, m_period, 32'd0);
    checkReg("mr_ctrl", A_CTRL, {29'd0, m_pol, m_irqen, m_en}, 32'd0);
    busWrite(A_CTRL, 32'h3);
    pin = 1'b1; tick(4);
    checkReg("mr_arm_only", A_STAT, {30'd0, m_ovr, m_valid}, 32'h0);
    tick(1);
    pin = 1'b0; tick(10);
    pin = 1'b1; tick(6);
    checkReg("mr_period2", A_PER, m_period, 32'd16);
    checkReg("mr_high2", A_HIGH, m_high, 32'd6);
    checkOutput("mr_irq", {31'd0, irq}, 32'd1);

    $display("[TB] saturation");
    pin = 1'b0; tick(5);
    busWrite(A_STAT, 32'h3);
    busWrite(A_PRE, 32'd0);
    pin = 1'b1; tick(6);
    force dut.counter = 32'hFFFF_FFF0;
    release dut.counter;
    tick(40);
    pin = 1'b0; tick(10);
    pin = 1'b1; tick(6);
    begin
      logic [31:0] d;
      busRead(A_PER, d);
      checkOutput("sat_period", d, 32'hFFFF_FFFF);
      busRead(A_HIGH, d);
      checkOutput("sat_high", d, 32'hFFFF_FFFF);
      busRead(A_STAT, d);
      checkOutput("sat_stat", d, 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_checks++;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
